// File: rtl/bp_be_prefetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_prefetch_scheduler
// Purpose  : Stream table fed by stride-detector start/confirm events, with a
//            round-robin issue of strided prefetches on a valid/ready port.
//            Optional: BP_BE_PREFETCH_DEDUP_EN suppresses same-line repeats.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_prefetch_scheduler #(
    parameter int VADDR_WIDTH       = 39,
    parameter int ENTRIES           = 4,
    parameter int DEGREE            = 2,
    parameter int DISTANCE          = 1,
    parameter int STRIDE_WIDTH      = 8,
    parameter int EADDR_WIDTH       = VADDR_WIDTH,
    parameter int LINE_OFFSET_WIDTH = 6
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_discovery_i,
    input  logic                    confirm_discovery_i,
    input  logic [VADDR_WIDTH-1:0]  striding_pc_i,
    input  logic [EADDR_WIDTH-1:0]  eff_addr_i,
    input  logic [STRIDE_WIDTH-1:0] stride_i,
    input  logic                    flush_i,
    output logic                    pf_v_o,
    output logic [EADDR_WIDTH-1:0]  pf_addr_o,
    input  logic                    pf_ready_i,
    output logic [ENTRIES-1:0]      active_streams_o
);

    localparam int c_idx_w  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int c_cred_w = $clog2(DEGREE + 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_issue = 1'b1;

    logic [0:0]             r_state, w_state_nxt;
    logic [ENTRIES-1:0]     r_valid;
    logic [VADDR_WIDTH-1:0] r_pc      [ENTRIES];
    logic [EADDR_WIDTH-1:0] r_next    [ENTRIES];
    logic [EADDR_WIDTH-1:0] r_stride  [ENTRIES];
    logic [c_cred_w-1:0]    r_credits [ENTRIES];
    logic [c_idx_w-1:0]     r_rr, r_victim, r_sel;
    logic                   r_pf_v, r_stale;
    logic [EADDR_WIDTH-1:0] r_pf_addr;

    logic                   w_hit, w_free, w_cand;
    logic [c_idx_w-1:0]     w_hit_idx, w_free_idx, w_cand_idx, w_alloc_idx, w_cons_idx;
    logic                   w_confirm, w_start, w_victim_adv, w_hs, w_skip, w_dedup, w_consume;
    logic                   w_touch_sel, w_touch_cand;
    logic [EADDR_WIDTH-1:0] w_stride_ext, w_dist_ofs;

    function automatic logic [c_idx_w-1:0] f_inc(input logic [c_idx_w-1:0] idx);
        return (int'(idx) == ENTRIES - 1) ? '0 : idx + 1'b1;
    endfunction

    // Descending scans leave the lowest matching index (or rr offset) last.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_cand     = 1'b0;
        w_cand_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_pc[i] == striding_pc_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_idx_w'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = c_idx_w'(i);
            end
        end
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            int j;
            j = (int'(r_rr) + k) % ENTRIES;
            if (r_valid[j] && (r_credits[j] != '0)) begin
                w_cand     = 1'b1;
                w_cand_idx = c_idx_w'(j);
            end
        end
    end

    assign w_stride_ext = {{(EADDR_WIDTH-STRIDE_WIDTH){stride_i[STRIDE_WIDTH-1]}}, stride_i};
    assign w_dist_ofs   = w_stride_ext * EADDR_WIDTH'(DISTANCE);

    assign w_confirm    = confirm_discovery_i && (stride_i != '0) && !flush_i;
    assign w_start      = start_discovery_i && !w_confirm && w_hit && !flush_i;
    assign w_alloc_idx  = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_victim);
    assign w_victim_adv = w_confirm && !w_hit && !w_free;

    // A retrain touching the chosen stream voids the credit of the in-flight request.
    assign w_touch_sel  = (w_confirm && (w_alloc_idx == r_sel))
                       || (w_start && (w_hit_idx == r_sel));
    assign w_touch_cand = (w_confirm && (w_alloc_idx == w_cand_idx))
                       || (w_start && (w_hit_idx == w_cand_idx));

    assign w_hs = (r_state == c_st_issue) && pf_ready_i;

`ifdef BP_BE_PREFETCH_DEDUP_EN
    logic                                     r_last_v;
    logic [EADDR_WIDTH-LINE_OFFSET_WIDTH-1:0] r_last_line;
    assign w_dedup = r_last_v
                  && (r_next[w_cand_idx][EADDR_WIDTH-1:LINE_OFFSET_WIDTH] == r_last_line);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_v    <= 1'b0;
            r_last_line <= '0;
        end else if (flush_i) begin
            r_last_v    <= 1'b0;
        end else if (w_hs) begin
            r_last_v    <= 1'b1;
            r_last_line <= r_pf_addr[EADDR_WIDTH-1:LINE_OFFSET_WIDTH];
        end
    end
`else
    assign w_dedup = 1'b0;
`endif

    assign w_skip     = !flush_i && (r_state == c_st_idle) && w_cand && w_dedup && !w_touch_cand;
    assign w_consume  = !flush_i && ((w_hs && !r_stale && !w_touch_sel) || w_skip);
    assign w_cons_idx = w_skip ? w_cand_idx : r_sel;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_cand && !w_skip) w_state_nxt = c_st_issue;
            c_st_issue: if (w_hs) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
        if (flush_i) w_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= c_st_idle;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid   <= '0;
            r_pf_v    <= 1'b0;
            r_pf_addr <= '0;
            r_sel     <= '0;
            r_stale   <= 1'b0;
            r_rr      <= '0;
            r_victim  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_pc[i]      <= '0;
                r_next[i]    <= '0;
                r_stride[i]  <= '0;
                r_credits[i] <= '0;
            end
        end else if (flush_i) begin
            r_valid  <= '0;
            r_pf_v   <= 1'b0;
            r_stale  <= 1'b0;
            r_rr     <= '0;
            r_victim <= '0;
        end else begin
            if (w_consume) begin
                r_next[w_cons_idx]    <= r_next[w_cons_idx] + r_stride[w_cons_idx];
                r_credits[w_cons_idx] <= r_credits[w_cons_idx] - 1'b1;
            end
            // Placed after the consume so a coincident confirm overrides it.
            if (w_confirm) begin
                r_valid[w_alloc_idx]   <= 1'b1;
                r_pc[w_alloc_idx]      <= striding_pc_i;
                r_next[w_alloc_idx]    <= eff_addr_i + w_dist_ofs;
                r_stride[w_alloc_idx]  <= w_stride_ext;
                r_credits[w_alloc_idx] <= c_cred_w'(DEGREE);
            end
            if (w_victim_adv) r_victim <= f_inc(r_victim);
            if (w_start) r_valid[w_hit_idx] <= 1'b0;

            if (r_state == c_st_idle) begin
                if (w_skip) begin
                    r_rr <= f_inc(w_cand_idx);
                end else if (w_cand) begin
                    r_pf_v    <= 1'b1;
                    r_pf_addr <= r_next[w_cand_idx];
                    r_sel     <= w_cand_idx;
                    r_stale   <= w_touch_cand;
                end
            end else if (w_hs) begin
                r_pf_v <= 1'b0;
                r_rr   <= f_inc(r_sel);
            end else begin
                r_stale <= r_stale | w_touch_sel;
            end
        end
    end

    assign pf_v_o           = r_pf_v;
    assign pf_addr_o        = r_pf_addr;
    assign active_streams_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_prefetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_prefetch_scheduler
// Purpose  : Directed scenarios plus random traffic against a stream-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_be_prefetch_scheduler;

    localparam int VW = 39;
    localparam int EW = 39;
`ifdef BP_BE_PREFETCH_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_discovery_i = 1'b0;
    logic          confirm_discovery_i = 1'b0;
    logic [VW-1:0] striding_pc_i = '0;
    logic [EW-1:0] eff_addr_i = '0;
    logic [7:0]    stride_i = '0;
    logic          flush_i = 1'b0;
    logic          pf_v_o;
    logic [EW-1:0] pf_addr_o;
    logic          pf_ready_i = 1'b0;
    logic [3:0]    active_streams_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    bp_be_prefetch_scheduler dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .start_discovery_i(start_discovery_i), .confirm_discovery_i(confirm_discovery_i),
        .striding_pc_i(striding_pc_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i),
        .flush_i(flush_i), .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o),
        .pf_ready_i(pf_ready_i), .active_streams_o(active_streams_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a table of streams and one outstanding request.
    typedef struct {
        bit            v;
        logic [VW-1:0] pc;
        logic [EW-1:0] nxt;
        logic [EW-1:0] str;
        int            cred;
    } ent_t;

    ent_t          tbl [4];
    int            m_rr, m_vic, m_sel;
    bit            m_pend, m_stale, m_lv;
    logic [EW-1:0] m_addr, m_lline;

    function automatic logic [3:0] m_act();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = tbl[i].v;
        return a;
    endfunction

    function automatic void m_clear_all();
        for (int i = 0; i < 4; i++) begin
            tbl[i].v = 0; tbl[i].pc = '0; tbl[i].nxt = '0; tbl[i].str = '0; tbl[i].cred = 0;
        end
        m_rr = 0; m_vic = 0; m_pend = 0; m_stale = 0; m_lv = 0;
    endfunction

    function automatic void m_use_credit(int k);
        tbl[k].nxt  = tbl[k].nxt + tbl[k].str;
        tbl[k].cred = tbl[k].cred - 1;
    endfunction

    function automatic void model_step(bit st, bit cf, logic [VW-1:0] pc, logic [EW-1:0] ea,
                                       logic [7:0] s, bit fl, bit rdy);
        ent_t          old [4];
        int            hit, free, tgt, cand;
        bit            ce, se;
        logic [EW-1:0] sx;
        old = tbl;
        hit = -1; free = -1; tgt = -1; cand = -1;
        if (fl) begin
            m_clear_all();
            return;
        end
        ce = cf && (s != 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (old[i].v && old[i].pc == pc && hit < 0) hit = i;
            if (!old[i].v && free < 0) free = i;
        end
        se = st && !ce && (hit >= 0);
        if (ce) tgt = (hit >= 0) ? hit : ((free >= 0) ? free : m_vic);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_rr + k) % 4;
            if (cand < 0 && old[j].v && old[j].cred > 0) cand = j;
        end
        sx = {{(EW-8){s[7]}}, s};

        if (m_pend) begin
            if (rdy) begin
                if (!m_stale && tgt != m_sel && !(se && hit == m_sel)) m_use_credit(m_sel);
                m_rr   = (m_sel + 1) % 4;
                m_pend = 0;
                m_lv   = 1;
                m_lline = m_addr >> 6;
            end else if (tgt == m_sel || (se && hit == m_sel)) begin
                m_stale = 1;
            end
        end else if (cand >= 0) begin
            if (DEDUP && m_lv && ((old[cand].nxt >> 6) == m_lline)
                && tgt != cand && !(se && hit == cand)) begin
                m_use_credit(cand);
                m_rr = (cand + 1) % 4;
            end else begin
                m_pend  = 1;
                m_addr  = old[cand].nxt;
                m_sel   = cand;
                m_stale = (tgt == cand) || (se && hit == cand);
            end
        end

        if (ce) begin
            tbl[tgt].v    = 1;
            tbl[tgt].pc   = pc;
            tbl[tgt].nxt  = ea + sx * EW'(1);
            tbl[tgt].str  = sx;
            tbl[tgt].cred = 2;
            if (hit < 0 && free < 0) m_vic = (m_vic + 1) % 4;
        end
        if (se) tbl[hit].v = 0;
    endfunction

    task automatic tick(input bit st, input bit cf, input logic [VW-1:0] pc,
                        input logic [EW-1:0] ea, input logic [7:0] s,
                        input bit fl, input bit rdy);
        start_discovery_i   = st;
        confirm_discovery_i = cf;
        striding_pc_i       = pc;
        eff_addr_i          = ea;
        stride_i            = s;
        flush_i             = fl;
        pf_ready_i          = rdy;
        @(posedge clk_i);
        model_step(st, cf, pc, ea, s, fl, rdy);
        #1;
    endtask

    task automatic idle(input bit rdy);
        tick(0, 0, '0, '0, 8'h00, 0, rdy);
    endtask

    task automatic confirm(input logic [VW-1:0] pc, input logic [EW-1:0] ea,
                           input logic [7:0] s, input bit rdy);
        tick(0, 1, pc, ea, s, 0, rdy);
    endtask

    task automatic do_flush();
        tick(0, 0, '0, '0, 8'h00, 1, 0);
    endtask

    task automatic test_reset();
        total_cnt++;
        if (pf_v_o !== 1'b0) $display("FAIL reset_pf_v: got %b expected 0", pf_v_o);
        else pass_cnt++;
        total_cnt++;
        if (pf_addr_o !== '0) $display("FAIL reset_pf_addr: got %h expected 0", pf_addr_o);
        else pass_cnt++;
        total_cnt++;
        if (active_streams_o !== 4'b0000) $display("FAIL reset_active: got %b expected 0000", active_streams_o);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [EW-1:0] exp_a [2];
        exp_a[0] = 39'h8040;
        exp_a[1] = 39'h8080;
        do_flush();
        confirm(39'h100, 39'h8000, 8'h40, 1);
        total_cnt++;
        if (pf_v_o !== 1'b0) $display("FAIL basic_latency: got pf_v %b expected 0", pf_v_o);
        else pass_cnt++;
        for (int r = 0; r < 2; r++) begin
            idle(1);
            total_cnt++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== exp_a[r])
                $display("FAIL basic_req%0d: got v=%b addr=%h expected v=1 addr=%h", r, pf_v_o, pf_addr_o, exp_a[r]);
            else pass_cnt++;
            idle(1);
            total_cnt++;
            if (pf_v_o !== 1'b0) $display("FAIL basic_gap%0d: got pf_v %b expected 0", r, pf_v_o);
            else pass_cnt++;
        end
        for (int c = 0; c < 4; c++) begin
            idle(1);
            total_cnt++;
            if (pf_v_o !== 1'b0) $display("FAIL basic_done: got pf_v %b expected 0", pf_v_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_victim();
        do_flush();
        for (int p = 0; p < 5; p++) confirm(39'h200 + 39'(p), 39'h4000, 8'h40, 0);
        total_cnt++;
        if (active_streams_o !== 4'b1111) $display("FAIL victim_full: got %b expected 1111", active_streams_o);
        else pass_cnt++;
        tick(1, 0, 39'h200, '0, 8'h00, 0, 0);
        total_cnt++;
        if (active_streams_o !== 4'b1111) $display("FAIL victim_evicted_pc: got %b expected 1111", active_streams_o);
        else pass_cnt++;
        tick(1, 0, 39'h204, '0, 8'h00, 0, 0);
        total_cnt++;
        if (active_streams_o !== 4'b1110) $display("FAIL victim_slot0: got %b expected 1110", active_streams_o);
        else pass_cnt++;
        total_cnt++;
        if (pf_v_o !== 1'b1) $display("FAIL victim_req_held: got pf_v %b expected 1", pf_v_o);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_flush();
        confirm(39'h110, 39'h8, 8'hF0, 1);
        idle(1);
        total_cnt++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h7F_FFFF_FFF8)
            $display("FAIL wrap_req0: got v=%b addr=%h expected v=1 addr=7ffffffff8", pf_v_o, pf_addr_o);
        else pass_cnt++;
        idle(1);
        idle(1);
        total_cnt++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h7F_FFFF_FFE8)
            $display("FAIL wrap_req1: got v=%b addr=%h expected v=1 addr=7fffffffe8", pf_v_o, pf_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] got [$];
        logic [EW-1:0] exp_q [4];
        exp_q[0] = 39'h1040; exp_q[1] = 39'h2020; exp_q[2] = 39'h1080; exp_q[3] = 39'h2040;
        do_flush();
        confirm(39'h300, 39'h1000, 8'h40, 0);
        confirm(39'h301, 39'h2000, 8'h20, 0);
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h1040)
                $display("FAIL stall_hold%0d: got v=%b addr=%h expected v=1 addr=1040", c, pf_v_o, pf_addr_o);
            else pass_cnt++;
            idle(0);
        end
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (pf_v_o === 1'b1) got.push_back(pf_addr_o);
            idle(1);
        end
        total_cnt++;
        if (got.size() != 4) $display("FAIL rr_count: got %0d requests expected 4", got.size());
        else pass_cnt++;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total_cnt++;
            if (got[i] !== exp_q[i]) $display("FAIL rr_order%0d: got %h expected %h", i, got[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        do_flush();
        confirm(39'h320, 39'h3000, 8'h40, 0);
        idle(0);
        total_cnt++;
        if (pf_v_o !== 1'b1) $display("FAIL flush_pre: got pf_v %b expected 1", pf_v_o);
        else pass_cnt++;
        tick(0, 1, 39'h321, 39'h5000, 8'h10, 1, 0);
        total_cnt++;
        if (pf_v_o !== 1'b0 || active_streams_o !== 4'b0000)
            $display("FAIL flush_drop: got v=%b active=%b expected v=0 active=0000", pf_v_o, active_streams_o);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            idle(1);
            total_cnt++;
            if (pf_v_o !== 1'b0) $display("FAIL flush_quiet%0d: got pf_v %b expected 0", c, pf_v_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_dedup();
        int extra;
        logic [EW-1:0] last_seen;
        extra = 0;
        last_seen = '0;
        do_flush();
        confirm(39'h400, 39'h1000, 8'h08, 1);
        idle(1);
        total_cnt++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h1008)
            $display("FAIL dedup_first: got v=%b addr=%h expected v=1 addr=1008", pf_v_o, pf_addr_o);
        else pass_cnt++;
        for (int c = 0; c < 8; c++) begin
            idle(1);
            if (pf_v_o === 1'b1) begin
                extra++;
                last_seen = pf_addr_o;
            end
        end
        total_cnt++;
        if (DEDUP) begin
            if (extra != 0) $display("FAIL dedup_suppress: got %0d extra requests expected 0", extra);
            else pass_cnt++;
        end else begin
            if (extra != 1 || last_seen !== 39'h1010)
                $display("FAIL dedup_off: got %0d extra last=%h expected 1 at 1010", extra, last_seen);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit            st, cf, fl, rdy;
        logic [VW-1:0] pc;
        logic [EW-1:0] ea;
        logic [7:0]    s;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(0, 9) == 0);
            cf  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 59) == 0);
            rdy = $urandom_range(0, 1);
            pc  = 39'h500 + 39'($urandom_range(0, 6));
            ea  = 39'({$urandom(), $urandom()});
            s   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            tick(st, cf, pc, ea, s, fl, rdy);
            total_cnt++;
            if (pf_v_o !== m_pend || pf_addr_o !== m_addr || active_streams_o !== m_act())
                $display("FAIL random_c%0d: got v=%b addr=%h act=%b expected v=%b addr=%h act=%b",
                         c, pf_v_o, pf_addr_o, active_streams_o, m_pend, m_addr, m_act());
            else pass_cnt++;
        end
    endtask

    initial begin
        m_clear_all();
        m_addr = '0;
        m_lline = '0;
        m_sel = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        test_reset();
        test_basic();
        test_victim();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_dedup();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
